// File: rtl/conv_mac_engine_pkg.sv
// Shared types and constants for the convolution MAC engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state encoding, datapath widths, 3x3 window size, requantiser helper.
package conv_mac_engine_pkg;

  localparam int PIX_W  = 8;
  localparam int WGT_W  = 8;
  localparam int ACC_W  = 24;
  localparam int BIAS_W = 16;
  localparam int WIN_N  = 9;
  // Bits per channel in a packed 3x3 window or kernel slice.
  localparam int CH_W   = WIN_N * PIX_W;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    KCLR,
    READY,
    MAC,
    OUT
  } state_t;

  // ReLU, then arithmetic right shift, then clamp to the 8-bit activation range.
  function automatic logic [PIX_W-1:0] requant(input logic signed [ACC_W-1:0] acc,
                                               input int shift);
    logic signed [ACC_W-1:0] pos;
    logic signed [ACC_W-1:0] shifted;
    pos     = acc[ACC_W-1] ? '0 : acc;
    shifted = pos >>> shift;
    if (shifted > 24'sd255) return 8'hFF;
    return shifted[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/conv_mac_engine_mac9.sv
// Nine-tap multiply-accumulate for one input channel of a 3x3 window.
// Latency: combinational.
// Backpressure: none; result follows inputs.
// Ports: pix (nine unsigned pixels), wgt (nine signed weights), sum (signed dot product).
module mac9
  import conv_mac_engine_pkg::*;
(
  input  logic        [CH_W-1:0]  pix,
  input  logic        [CH_W-1:0]  wgt,
  output logic signed [ACC_W-1:0] sum
);

  // Pixel is zero-extended to 9 bits so the signed multiply treats it as unsigned.
  logic signed [PIX_W+WGT_W:0] prod;

  always_comb begin
    sum  = '0;
    prod = '0;
    for (int k = 0; k < WIN_N; k++) begin
      prod = $signed({1'b0, pix[k*PIX_W +: PIX_W]}) * $signed(wgt[k*WGT_W +: WGT_W]);
      sum  = sum + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/conv_mac_engine.sv
// Per-output-channel 3x3 conv engine: load kernel, then MAC one channel per cycle per window.
// Latency: window accepted at T, result valid at T+IC+2.
// Backpressure: win_ready only in READY; result held in OUT until res_ready.
// Ports: start/out_c/bias begin a pass; c_load/c_load_done/kernel_flat/ld_out_c talk to the
//        kernel loader; win_* is the window input; res_* the activation output; busy/done status.
module conv_mac_engine
  import conv_mac_engine_pkg::*;
#(
  parameter int IC    = 0,
  parameter int SHIFT = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [3:0]                 out_c,
  input  logic signed [BIAS_W-1:0]   bias,
  output logic                       c_load,
  input  logic                       c_load_done,
  input  logic [(IC+1)*CH_W-1:0]     kernel_flat,
  output logic [3:0]                 ld_out_c,
  input  logic                       win_valid,
  output logic                       win_ready,
  input  logic [(IC+1)*CH_W-1:0]     win_data,
  input  logic                       win_last,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [PIX_W-1:0]           res_data,
  output logic                       busy,
  output logic                       done
);

  localparam int NCH    = IC + 1;
  localparam int FLAT_W = NCH * CH_W;

  state_t                   state, state_nx;
  logic [FLAT_W-1:0]        kernel_q;
  logic [FLAT_W-1:0]        win_q;
  logic                     win_last_q;
  logic signed [BIAS_W-1:0] bias_q;
  logic [3:0]               cnt;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_nx;
  logic signed [ACC_W-1:0]  ch_sum;
  logic [CH_W-1:0]          pix_sel;
  logic [CH_W-1:0]          wgt_sel;
  logic                     mac_last;

  // Channel mux driven by the MAC counter; constant slices keep every select in range.
  always_comb begin
    pix_sel = '0;
    wgt_sel = '0;
    for (int c = 0; c < NCH; c++) begin
      if (cnt == 4'(c)) begin
        pix_sel = win_q[c*CH_W +: CH_W];
        wgt_sel = kernel_q[c*CH_W +: CH_W];
      end
    end
  end

  mac9 u_mac9 (
    .pix (pix_sel),
    .wgt (wgt_sel),
    .sum (ch_sum)
  );

  assign acc_nx   = acc + ch_sum;
  assign mac_last = (cnt == 4'(IC));
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    c_load    = 1'b0;
    win_ready = 1'b0;
    res_valid = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:  if (start) state_nx = LOAD;
      LOAD: begin
        c_load = 1'b1;
        if (c_load_done) state_nx = KCLR;
      end
      // Wait for the loader to drop its acknowledge so a held ack is never re-used.
      KCLR:  if (!c_load_done) state_nx = READY;
      READY: begin
        win_ready = 1'b1;
        if (win_valid) state_nx = MAC;
      end
      MAC:   if (mac_last) state_nx = OUT;
      OUT: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_nx = win_last_q ? IDLE : READY;
          done     = win_last_q;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_out_c   <= '0;
      bias_q     <= '0;
      kernel_q   <= '0;
      win_q      <= '0;
      win_last_q <= 1'b0;
      acc        <= '0;
      cnt        <= '0;
      res_data   <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          ld_out_c <= out_c;
          bias_q   <= bias;
        end
        LOAD: if (c_load_done) kernel_q <= kernel_flat;
        READY: if (win_valid) begin
          win_q      <= win_data;
          win_last_q <= win_last;
          acc        <= ACC_W'(bias_q);
          cnt        <= '0;
        end
        MAC: begin
          acc <= acc_nx;
          cnt <= cnt + 4'd1;
          if (mac_last) res_data <= requant(acc_nx, SHIFT);
        end
        default: ;
      endcase
    end
  end

endmodule
